fill_xcel: RTL and testbench
============================

FILL_XCEL -- requirements
Module: fill_xcel

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port in_val, input, 1, command valid.
REQ-004 SHALL have port in_rdy, output, 1, command ready (block idle).
REQ-005 SHALL have port in_size, input, 7, number of words to write (0..127).
REQ-006 SHALL have port data_val, input, 1, stream word valid.
REQ-007 SHALL have port data_rdy, output, 1, stream word accepted this cycle.
REQ-008 SHALL have port data, input, 32, stream word.
REQ-009 SHALL have port mem_val, output, 1, memory request valid.
REQ-010 SHALL have port mem_wait, input, 1, memory stall; request not taken this cycle.
REQ-011 SHALL have port mem_type, output, 1, 1 = write; always 1.
REQ-012 SHALL have port mem_addr, output, 32, word byte address.
REQ-013 SHALL have port mem_wdata, output, 32, write data.
REQ-014 SHALL have port count, output, 7, words written by the last or current command.
REQ-015 SHALL have port checksum, output, 32, see Configuration.

Function
REQ-016 SHALL fill a region from address 0x000 upward, one word per 4 bytes, feeding the downstream accumulator, which reads from 0x000.
REQ-017 SHALL implement states IDLE, RECV, WRITE.
REQ-018 SHALL assert in_rdy only in IDLE; a command is accepted on in_val && in_rdy.
REQ-019 SHALL, on accept with in_size==0, stay in IDLE, set count=0, and issue no memory request.
REQ-020 SHALL, on accept with in_size>0, latch size, clear count, and go to RECV.
REQ-021 SHALL assert data_rdy only in RECV; on data_val && data_rdy, it latches data into the word buffer and goes to WRITE.
REQ-022 SHALL hold mem_val=1 in WRITE, with mem_addr = {count,2'b00} zero-extended and mem_wdata = buffered word.
REQ-023 SHALL keep mem_addr and mem_wdata stable while mem_wait=1 and stay in WRITE.
REQ-024 SHALL, on WRITE with mem_wait=0, increment count; if the new count equals size it goes to IDLE, else to RECV.
REQ-025 SHALL take at least 2 cycles per word (RECV then WRITE), plus one cycle per mem_wait stall.
REQ-026 SHALL keep mem_val=0 and data_rdy=0 in IDLE; it SHALL ignore data_val outside RECV.
REQ-027 SHALL hold count after completion until the next accepted command.
REQ-028 SHALL ignore in_val while not in IDLE.

Reset
REQ-029 SHALL, when rst is low, immediately force state=IDLE, count=0, checksum=0, word buffer=0, and stored size=0, independent of clk.
REQ-030 SHALL drive outputs after reset to in_rdy=1, data_rdy=0, mem_val=0, mem_addr=0, and mem_wdata=0.
REQ-031 SHALL abandon a command on reset mid-operation; already completed writes remain in memory, and no partial request is retried.

Configuration
REQ-032 SHALL, when FILL_XCEL_CHECKSUM_EN is defined, maintain checksum as the modulo-2^32 sum of words whose write completed, cleared on command accept.
REQ-033 SHALL, when FILL_XCEL_CHECKSUM_EN is undefined, drive checksum constant 0 and contain no adder.

Structure
REQ-034 SHALL place the state enum (IDLE/RECV/WRITE), MEM_TYPE_WRITE=1'b1, and WORD_BYTES=4 in shared package fill_xcel_pkg.
REQ-035 SHALL use one sub-module, fill_xcel_wbuf, a 32-bit enabled register with async active-low reset for the word buffer.

Verification
REQ-036 SHALL verify basic fill: size=4, stream 1,2,3,4, mem_wait=0 -> writes 0x000=1, 0x004=2, 0x008=3, 0x00c=4; count=4; in_rdy=1 after 8 cycles; checksum=10 when enabled.
REQ-037 SHALL verify size 0: in_val=1 with size=0 -> no mem_val for 10 cycles; in_rdy stays 1; count=0.
REQ-038 SHALL verify stall: size=2, mem_wait=1 for 3 cycles on the first write -> mem_addr=0x000 and mem_wdata held; 0x004 is written after; count=2.
REQ-039 SHALL verify stream bubbles: size=3 with data_val low 2 cycles between words -> data_rdy stays high in RECV; writes 7,8,9 at 0x000..0x008.
REQ-040 SHALL verify reset mid-operation: size=4, rst low after the second write -> in_rdy=1, count=0, mem_val=0 immediately; a new size=1 command writes 0x000.
REQ-041 SHALL verify end-to-end: fill size=3 with 5,6,7, then the accumulator in_size=3 -> result=18.

Source files
------------

// File: rtl/fill_xcel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fill_xcel_pkg
// Purpose  : Shared types and constants for the fill accelerator: the
//            controller state encoding, the memory request type code and the
//            number of bytes per memory word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fill_xcel_pkg;

  // Controller states: wait for a command, wait for a stream word,
  // write the buffered word to memory.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic        MEM_TYPE_WRITE = 1'b1;
  localparam int unsigned WORD_BYTES     = 4;

endpackage
`default_nettype wire

// File: rtl/fill_xcel_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : fill_xcel_wbuf
// Purpose  : Word buffer holding the most recently accepted stream word until
//            it has been written to memory. Loads when en_i is high; cleared
//            asynchronously while rst is low.
// Ports    : clk   - clock
//            rst   - asynchronous active-low reset
//            en_i  - load enable
//            d_i   - word to load
//            q_o   - buffered word
// Revision : 1.0 - initial release
// ============================================================================
module fill_xcel_wbuf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else if (en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule
`default_nettype wire

// File: rtl/fill_xcel.sv
`default_nettype none
// ============================================================================
// Module   : fill_xcel
// Purpose  : Fill accelerator. Accepts a command of in_size words, then for
//            each word takes one value from the input stream and writes it to
//            memory at byte address 4*index, starting from 0x000. Each word
//            costs one RECV cycle plus one WRITE cycle per attempt.
// Ports    : clk, rst (async active-low)
//            in_val/in_rdy/in_size      - command handshake and word count
//            data_val/data_rdy/data     - stream word handshake
//            mem_val/mem_wait/mem_type/mem_addr/mem_wdata - write request
//            count                      - words written by last/current command
//            checksum                   - sum of written words (optional)
// Config   : FILL_XCEL_CHECKSUM_EN - when defined, checksum accumulates the
//            modulo-2^32 sum of completed writes; otherwise it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fill_xcel
  import fill_xcel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [6:0]  in_size,
  input  logic        data_val,
  output logic        data_rdy,
  input  logic [31:0] data,
  output logic        mem_val,
  input  logic        mem_wait,
  output logic        mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [6:0]  count,
  output logic [31:0] checksum
);

  state_e      state_q;
  logic [6:0]  size_q;
  logic [6:0]  count_q;
  logic [6:0]  count_d;
  logic        in_rdy_q;
  logic        data_rdy_q;
  logic        mem_val_q;
  logic [31:0] wbuf_q;

  // in_rdy_q / data_rdy_q / mem_val_q are registered copies of
  // (state == IDLE / RECV / WRITE), so they double as state decodes here.
  logic cmd_accept;
  logic word_accept;
  logic wr_done;

  assign cmd_accept  = in_rdy_q && in_val;
  assign word_accept = data_rdy_q && data_val;
  assign wr_done     = mem_val_q && !mem_wait;
  assign count_d     = count_q + 7'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      size_q     <= '0;
      count_q    <= '0;
      in_rdy_q   <= 1'b1;
      data_rdy_q <= 1'b0;
      mem_val_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_val) begin
            count_q <= '0;
            // A zero-length command completes on the spot.
            if (in_size != 7'd0) begin
              size_q     <= in_size;
              state_q    <= RECV;
              in_rdy_q   <= 1'b0;
              data_rdy_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (data_val) begin
            state_q    <= WRITE;
            data_rdy_q <= 1'b0;
            mem_val_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (!mem_wait) begin
            count_q   <= count_d;
            mem_val_q <= 1'b0;
            if (count_d == size_q) begin
              state_q  <= IDLE;
              in_rdy_q <= 1'b1;
            end else begin
              state_q    <= RECV;
              data_rdy_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_rdy_q   <= 1'b1;
          data_rdy_q <= 1'b0;
          mem_val_q  <= 1'b0;
        end
      endcase
    end
  end

  fill_xcel_wbuf #(
    .WIDTH (32)
  ) u_wbuf (
    .clk  (clk),
    .rst  (rst),
    .en_i (word_accept),
    .d_i  (data),
    .q_o  (wbuf_q)
  );

`ifdef FILL_XCEL_CHECKSUM_EN
  logic [31:0] checksum_q;
  logic [31:0] checksum_d;

  assign checksum_d = checksum_q + wbuf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (cmd_accept) begin
      checksum_q <= '0;
    end else if (wr_done) begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  // Handshake terms only feed the checksum; keep them referenced.
  logic unused_ok;
  assign unused_ok = cmd_accept ^ wr_done;
  assign checksum  = 32'd0;
`endif

  // Address tracks the write index directly, so it stays put while stalled.
  assign mem_addr  = 32'(count_q) * 32'(WORD_BYTES);
  assign mem_wdata = wbuf_q;
  assign mem_type  = MEM_TYPE_WRITE;
  assign mem_val   = mem_val_q;
  assign in_rdy    = in_rdy_q;
  assign data_rdy  = data_rdy_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fill_xcel.sv
`default_nettype none
// ============================================================================
// Module   : tb_fill_xcel
// Purpose  : Directed self-checking bench for fill_xcel. A stream feeder and a
//            memory-stall driver run beside the stimulus thread; a monitor
//            logs every completed write into a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fill_xcel;

`ifdef FILL_XCEL_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int TIMEOUT = 500;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [6:0]  in_size;
  logic        data_val;
  logic        data_rdy;
  logic [31:0] data;
  logic        mem_val;
  logic        mem_wait;
  logic        mem_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;
  logic [31:0] checksum;

  fill_xcel dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_size   (in_size),
    .data_val  (data_val),
    .data_rdy  (data_rdy),
    .data      (data),
    .mem_val   (mem_val),
    .mem_wait  (mem_wait),
    .mem_type  (mem_type),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .checksum  (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream feeder, stall driver and monitor state
  logic [31:0] feed_q[$];
  int          feed_gap   = 0;
  int          gap_cnt    = 0;
  int          stall_left = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] mem_model [0:127];
  logic [31:0] stall_addr_exp = '0;
  logic [31:0] stall_data_exp = '0;
  int stall_n   = 0;
  int stall_bad = 0;
  int bubble_n  = 0;
  int memval_n  = 0;
  int busy_n    = 0;
  int type_bad  = 0;

  // Monitor: observes the cycle that ends at this edge.
  always @(posedge clk) begin
    if (rst) begin
      if (mem_val && !mem_wait) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        mem_model[mem_addr[8:2]] = mem_wdata;
        if (mem_type !== 1'b1) type_bad++;
      end
      if (mem_val && mem_wait) begin
        stall_n++;
        if (mem_addr !== stall_addr_exp || mem_wdata !== stall_data_exp) stall_bad++;
      end
      if (data_rdy && !data_val) bubble_n++;
      if (mem_val) memval_n++;
      if (!in_rdy) busy_n++;
    end
  end

  // Feeder / stall driver: updates inputs 1 time unit after each edge.
  always @(posedge clk) begin
    if (rst && data_val && data_rdy) begin
      void'(feed_q.pop_front());
      gap_cnt = (feed_gap > 0) ? feed_gap + 1 : 0;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    #1;
    if (feed_q.size() > 0 && gap_cnt == 0) begin
      data_val = 1'b1;
      data     = feed_q[0];
    end else begin
      data_val = 1'b0;
      data     = '0;
    end
    if (stall_left > 0 && mem_val) begin
      mem_wait = 1'b1;
      stall_left--;
    end else begin
      mem_wait = 1'b0;
    end
  end

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    stall_n  = 0;
    stall_bad = 0;
    bubble_n = 0;
    memval_n = 0;
    busy_n   = 0;
  endtask

  // Issue a command and wait (bounded) for in_rdy; cyc counts edges after accept.
  task automatic run_cmd(input logic [6:0] sz, output int cyc);
    @(posedge clk); #1;
    in_val  = 1'b1;
    in_size = sz;
    @(posedge clk); #1;
    in_val  = 1'b0;
    in_size = '0;
    cyc = 0;
    while (!in_rdy && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] ed [4];
    ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i * 4));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int wait_n;
    logic [31:0] acc;

    rst = 1'b0; in_val = 1'b0; in_size = '0;
    data_val = 1'b0; data = '0; mem_wait = 1'b0;
    for (int i = 0; i < 128; i++) mem_model[i] = '0;

    // Reset values, both during and just after reset
    #12;
    check("rst_in_rdy",   32'(in_rdy),   32'd1);
    check("rst_data_rdy", 32'(data_rdy), 32'd0);
    check("rst_mem_val",  32'(mem_val),  32'd0);
    #10 rst = 1'b1;
    #1;
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_count",     32'(count), 32'd0);
    check("rst_checksum",  checksum,  32'd0);
    check("mem_type",      32'(mem_type), 32'd1);

    // Basic fill: size 4, words 1..4, no stalls
    clear_logs();
    feed_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_cmd(7'd4, cyc);
    check("basic_cycles", 32'(cyc), 32'd8);
    check_writes("basic", 4, 32'd1, 32'd2, 32'd3, 32'd4);
    check("basic_count",  32'(count), 32'd4);
    check("basic_in_rdy", 32'(in_rdy), 32'd1);
    check("basic_checksum", checksum, CHK_EN ? 32'd10 : 32'd0);
    check("basic_no_bubble", 32'(bubble_n), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("basic_count_hold", 32'(count), 32'd4);

    // Size 0: in_val held for 10 cycles
    clear_logs();
    @(posedge clk); #1;
    in_val = 1'b1; in_size = 7'd0;
    repeat (10) @(posedge clk);
    #1 in_val = 1'b0;
    check("zero_mem_val", 32'(memval_n), 32'd0);
    check("zero_busy",    32'(busy_n),   32'd0);
    check("zero_count",   32'(count),    32'd0);
    check("zero_in_rdy",  32'(in_rdy),   32'd1);

    // Stall: 3 wait cycles on the first write
    clear_logs();
    stall_addr_exp = 32'h0;
    stall_data_exp = 32'hA1;
    stall_left = 3;
    feed_q = '{32'hA1, 32'hB2};
    run_cmd(7'd2, cyc);
    check("stall_cycles", 32'(cyc), 32'd7);
    check("stall_n",      32'(stall_n), 32'd3);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check_writes("stall", 2, 32'hA1, 32'hB2, 32'd0, 32'd0);
    check("stall_count", 32'(count), 32'd2);

    // Stream bubbles: two idle stream cycles between words
    clear_logs();
    feed_gap = 2;
    feed_q = '{32'd7, 32'd8, 32'd9};
    run_cmd(7'd3, cyc);
    feed_gap = 0;
    check("bubble_cycles", 32'(cyc), 32'd10);
    check("bubble_rdy_n",  32'(bubble_n), 32'd4);
    check_writes("bubble", 3, 32'd7, 32'd8, 32'd9, 32'd0);

    // Reset mid-operation after the second write
    clear_logs();
    repeat (4) @(posedge clk);
    feed_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    @(posedge clk); #1;
    in_val = 1'b1; in_size = 7'd4;
    @(posedge clk); #1;
    in_val = 1'b0; in_size = '0;
    wait_n = 0;
    while (wr_addr.size() < 2 && wait_n < TIMEOUT) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("rmid_two_writes", 32'(wr_addr.size()), 32'd2);
    #1;
    rst = 1'b0;
    feed_q.delete();
    data_val = 1'b0;
    #1;
    check("rmid_in_rdy",   32'(in_rdy),   32'd1);
    check("rmid_count",    32'(count),    32'd0);
    check("rmid_mem_val",  32'(mem_val),  32'd0);
    check("rmid_data_rdy", 32'(data_rdy), 32'd0);
    check("rmid_checksum", checksum,      32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    feed_q = '{32'h55};
    run_cmd(7'd1, cyc);
    check("rmid_new_cycles", 32'(cyc), 32'd2);
    check_writes("rmid_new", 1, 32'h55, 32'd0, 32'd0, 32'd0);
    check("rmid_new_count", 32'(count), 32'd1);

    // End-to-end: fill 5,6,7 then accumulate three words from 0x000
    clear_logs();
    feed_q = '{32'd5, 32'd6, 32'd7};
    run_cmd(7'd3, cyc);
    acc = '0;
    for (int i = 0; i < 3; i++) acc = acc + mem_model[i];
    check("e2e_result",   acc, 32'd18);
    check("e2e_checksum", checksum, CHK_EN ? 32'd18 : 32'd0);
    check("mem_type_writes", 32'(type_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
